// File: rtl/floo_eject_sink_if.sv
// Eject-port flit handshake bundle: router side is master, sink side is slave.
interface floo_eject_sink_if #(
  parameter int unsigned NumChannels = 3,
  parameter int unsigned FlitWidth   = 64
);
  logic [NumChannels-1:0]           valid;
  logic [NumChannels-1:0]           ready;
  logic [NumChannels-1:0]           last;
  logic [NumChannels*FlitWidth-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/floo_eject_sink.sv
// Traffic sink for unused router Eject ports: consumes flits under drain/throttle/stall
// modes, counts flits/packets, keeps each packet's header flit and flags protocol errors.
module floo_eject_sink #(
  parameter int unsigned NumChannels = 3,
  parameter int unsigned FlitWidth   = 64,
  parameter int unsigned CntWidth    = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic [1:0]                       mode_i,
  input  logic [7:0]                       duty_i,
  floo_eject_sink_if.slave                 ej,
  output logic [NumChannels-1:0]           inj_valid_o,
  output logic [NumChannels*CntWidth-1:0]  flit_cnt_o,
  output logic [NumChannels*CntWidth-1:0]  pkt_cnt_o,
  output logic [NumChannels*FlitWidth-1:0] hdr_o,
  output logic [NumChannels-1:0]           err_o
);

  localparam logic [1:0] MODE_DRAIN    = 2'd0;
  localparam logic [1:0] MODE_THROTTLE = 2'd1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  logic [1:0]           mode_q;
  logic [7:0]           tcnt_q     [NumChannels];
  logic [0:0]           state_q    [NumChannels];
  logic [CntWidth-1:0]  flit_cnt_q [NumChannels];
  logic [CntWidth-1:0]  pkt_cnt_q  [NumChannels];
  logic [FlitWidth-1:0] hdr_q      [NumChannels];
  logic [FlitWidth-1:0] data_q     [NumChannels];
  logic [NumChannels-1:0] last_q, stalled_q, err_q;
  logic [NumChannels-1:0] rdy, acc;

  // ready is gated by rst_i so it drops the instant reset asserts
  always_comb begin
    rdy = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      case (mode_i)
        MODE_DRAIN:    rdy[c] = 1'b1;
        MODE_THROTTLE: rdy[c] = (tcnt_q[c] == 8'd0);
        default:       rdy[c] = 1'b0;
      endcase
    end
    rdy = rdy & {NumChannels{~rst_i}};
  end

  assign ej.ready    = rdy;
  assign acc         = ej.valid & rdy;
  assign inj_valid_o = '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q    <= MODE_DRAIN;
      last_q    <= '0;
      stalled_q <= '0;
      err_q     <= '0;
      for (int unsigned c = 0; c < NumChannels; c++) begin
        tcnt_q[c]     <= '0;
        state_q[c]    <= ST_IDLE;
        flit_cnt_q[c] <= '0;
        pkt_cnt_q[c]  <= '0;
        hdr_q[c]      <= '0;
        data_q[c]     <= '0;
      end
    end else begin
      mode_q <= mode_i;
      for (int unsigned c = 0; c < NumChannels; c++) begin
        // throttle counter is independent of clear_i so ready_o is unaffected by it
        if (mode_i != mode_q)
          tcnt_q[c] <= '0;
        else if (mode_i == MODE_THROTTLE) begin
          if (acc[c] || (tcnt_q[c] == 8'd0 && !ej.valid[c]))
            tcnt_q[c] <= duty_i;
          else if (tcnt_q[c] != 8'd0)
            tcnt_q[c] <= tcnt_q[c] - 8'd1;
        end else
          tcnt_q[c] <= '0;

        if (clear_i) begin
          state_q[c]    <= ST_IDLE;
          flit_cnt_q[c] <= '0;
          pkt_cnt_q[c]  <= '0;
          hdr_q[c]      <= '0;
          err_q[c]      <= 1'b0;
          stalled_q[c]  <= 1'b0;
        end else begin
          stalled_q[c] <= ej.valid[c] & ~rdy[c];
          data_q[c]    <= ej.data[c*FlitWidth +: FlitWidth];
          last_q[c]    <= ej.last[c];
          if (stalled_q[c] && (!ej.valid[c] || ej.last[c] != last_q[c] ||
                               ej.data[c*FlitWidth +: FlitWidth] != data_q[c]))
            err_q[c] <= 1'b1;
          if (acc[c]) begin
            if (flit_cnt_q[c] != '1) flit_cnt_q[c] <= flit_cnt_q[c] + 1'b1;
            if (ej.last[c] && pkt_cnt_q[c] != '1) pkt_cnt_q[c] <= pkt_cnt_q[c] + 1'b1;
            if (state_q[c] == ST_IDLE) hdr_q[c] <= ej.data[c*FlitWidth +: FlitWidth];
            state_q[c] <= ej.last[c] ? ST_IDLE : ST_BODY;
          end
        end
      end
    end
  end

  always_comb begin
    flit_cnt_o = '0;
    pkt_cnt_o  = '0;
    hdr_o      = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      flit_cnt_o[c*CntWidth +: CntWidth]  = flit_cnt_q[c];
      pkt_cnt_o[c*CntWidth +: CntWidth]   = pkt_cnt_q[c];
      hdr_o[c*FlitWidth +: FlitWidth]     = hdr_q[c];
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_floo_eject_sink.sv
// Directed bench for floo_eject_sink: drain, throttle, stall/protocol error, saturation,
// clear-vs-accept priority and asynchronous reset mid-packet.
module tb_floo_eject_sink;

  localparam int unsigned NC = 3;
  localparam int unsigned FW = 64;
  localparam int unsigned CW = 32;
  localparam int unsigned CWB = 4;

  logic clk = 1'b0;
  logic rst, clear;
  logic [1:0] mode;
  logic [7:0] duty;

  logic [NC-1:0]     inj_a, err_a, inj_b, err_b;
  logic [NC*CW-1:0]  fcnt_a, pcnt_a;
  logic [NC*CWB-1:0] fcnt_b, pcnt_b;
  logic [NC*FW-1:0]  hdr_a, hdr_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  floo_eject_sink_if #(.NumChannels(NC), .FlitWidth(FW)) ifa ();
  floo_eject_sink_if #(.NumChannels(NC), .FlitWidth(FW)) ifb ();

  floo_eject_sink #(.NumChannels(NC), .FlitWidth(FW), .CntWidth(CW)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .mode_i(mode), .duty_i(duty),
    .ej(ifa.slave), .inj_valid_o(inj_a), .flit_cnt_o(fcnt_a), .pkt_cnt_o(pcnt_a),
    .hdr_o(hdr_a), .err_o(err_a)
  );

  floo_eject_sink #(.NumChannels(NC), .FlitWidth(FW), .CntWidth(CWB)) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .mode_i(mode), .duty_i(duty),
    .ej(ifb.slave), .inj_valid_o(inj_b), .flit_cnt_o(fcnt_b), .pkt_cnt_o(pcnt_b),
    .hdr_o(hdr_b), .err_o(err_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs are sampled there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] fc(input int unsigned c);
    return fcnt_a[c*CW +: CW];
  endfunction
  function automatic logic [CW-1:0] pc(input int unsigned c);
    return pcnt_a[c*CW +: CW];
  endfunction
  function automatic logic [FW-1:0] hd(input int unsigned c);
    return hdr_a[c*FW +: FW];
  endfunction

  task automatic send_a(input int unsigned c, input logic [FW-1:0] d, input logic lst);
    ifa.valid[c]            = 1'b1;
    ifa.data[c*FW +: FW]    = d;
    ifa.last[c]             = lst;
    step();
    ifa.valid[c]            = 1'b0;
  endtask

  initial begin
    logic [15:0] rpat;
    bit found;
    rst = 1'b1; clear = 1'b0; mode = 2'd0; duty = 8'd0;
    ifa.valid = '0; ifa.last = '0; ifa.data = '0;
    ifb.valid = '0; ifb.last = '0; ifb.data = '0;
    #1;
    step();
    check("rst_ready", {61'd0, ifa.ready}, 64'd0);
    check("rst_fcnt0", fc(0), 0);
    check("rst_pcnt2", pc(2), 0);
    check("rst_hdr1", hd(1), 0);
    check("rst_err", {61'd0, err_a}, 64'd0);
    check("inj_valid", {61'd0, inj_a}, 64'd0);
    rst = 1'b0;
    step();
    check("drain_ready", {61'd0, ifa.ready}, 64'd7);

    // 3-flit packet on ch0 in DRAIN
    send_a(0, 64'h11, 1'b0);
    send_a(0, 64'h22, 1'b0);
    send_a(0, 64'h33, 1'b1);
    check("pkt3_fcnt0", fc(0), 3);
    check("pkt3_pcnt0", pc(0), 1);
    check("pkt3_hdr0", hd(0), 64'h11);

    // THROTTLE duty 3: phase valid so the 16th held cycle is an accept
    mode = 2'd1; duty = 8'd3;
    step();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (ifa.ready[1]) found = 1'b1;
      else step();
    end
    check("thr_ready_seen", {63'd0, found}, 64'd1);
    step();
    ifa.valid[1] = 1'b1; ifa.last[1] = 1'b1; ifa.data[FW +: FW] = 64'h77;
    rpat = '0;
    for (int i = 0; i < 16; i++) begin
      rpat[i] = ifa.ready[1];
      step();
    end
    ifa.valid[1] = 1'b0;
    step();
    check("thr_ready_pat", {48'd0, rpat}, 64'h8888);
    check("thr_fcnt1", fc(1), 4);
    check("thr_pcnt1", pc(1), 4);
    check("thr_err1", {63'd0, err_a[1]}, 64'd0);

    // STALL with payload changed while stalled
    mode = 2'd2;
    step();
    ifa.valid[2] = 1'b1; ifa.last[2] = 1'b0; ifa.data[2*FW +: FW] = 64'hA5;
    step();
    check("stall_ready2", {63'd0, ifa.ready[2]}, 64'd0);
    check("stall_err_pre", {63'd0, err_a[2]}, 64'd0);
    ifa.data[2*FW +: FW] = 64'h5A;
    step();
    check("stall_err2", {63'd0, err_a[2]}, 64'd1);
    check("stall_fcnt2", fc(2), 0);
    clear = 1'b1; ifa.valid[2] = 1'b0;
    step();
    clear = 1'b0;
    check("clr_err2", {63'd0, err_a[2]}, 64'd0);
    check("clr_fcnt0", fc(0), 0);
    step();
    check("clr_err2_hold", {63'd0, err_a[2]}, 64'd0);

    // saturation on the 4-bit-counter instance
    mode = 2'd0;
    step();
    ifb.valid[0] = 1'b1; ifb.last[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ifb.data[0 +: FW] = 64'(i);
      step();
    end
    ifb.valid[0] = 1'b0;
    check("sat_fcnt", {60'd0, fcnt_b[0 +: CWB]}, 64'd15);
    check("sat_pcnt", {60'd0, pcnt_b[0 +: CWB]}, 64'd15);
    check("sat_hdr", hdr_b[0 +: FW], 64'd19);

    // clear coincident with a body accept: not counted, FSM back to IDLE
    send_a(0, 64'hAA, 1'b0);
    check("pre_clr_fcnt0", fc(0), 1);
    check("pre_clr_hdr0", hd(0), 64'hAA);
    clear = 1'b1;
    send_a(0, 64'hBB, 1'b0);
    clear = 1'b0;
    check("clracc_fcnt0", fc(0), 0);
    check("clracc_hdr0", hd(0), 0);
    send_a(0, 64'hCC, 1'b1);
    check("postclr_hdr0", hd(0), 64'hCC);
    check("postclr_pcnt0", pc(0), 1);

    // async reset in BODY
    send_a(0, 64'hDD, 1'b0);
    ifa.valid[0] = 1'b1; ifa.data[0 +: FW] = 64'hEE; ifa.last[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", {61'd0, ifa.ready}, 64'd0);
    check("arst_fcnt0", fc(0), 0);
    check("arst_hdr0", hd(0), 0);
    ifa.valid[0] = 1'b0;
    step();
    rst = 1'b0;
    step();
    send_a(0, 64'h12, 1'b0);
    send_a(0, 64'h34, 1'b1);
    check("post_rst_hdr0", hd(0), 64'h12);
    check("post_rst_fcnt0", fc(0), 2);
    check("post_rst_pcnt0", pc(0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
